pattern_seq_gen: RTL

Parametrised multi-channel serial pattern generator: a synchronous modulo-(LEN+1) index counter walks a bank of per-channel pattern registers and drives one bit per channel per clock. It generalises the fixed decade counter + 16-word ROM + bit-select mux chain into one synchronous block with these additions:
- runtime length
- one-shot and continuous modes
- start/stop control
- loadable patterns and several channels

It sits between the control/sequencing logic and any consumer of timed serial enable/strobe patterns.

---
 rtl/pattern_seq_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pattern_seq_gen.sv
// Multi-channel serial pattern generator: a modulo-(LEN+1) index walks
// per-channel pattern registers and emits one bit per channel per clock.

module pattern_seq_chan #(
    parameter int               DEPTH    = 16,
    parameter int               AW       = 4,
    parameter logic [DEPTH-1:0] INIT_PAT = 16'h1C3F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [DEPTH-1:0] pat_in,
    input  logic             busy,
    input  logic [AW-1:0]    idx,
    output logic             out_bit
);
    logic [DEPTH-1:0] pat_q, pat_d;

    always_comb begin
        pat_d = pat_q;
        if (we) pat_d = pat_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat_q <= INIT_PAT;
        else        pat_q <= pat_d;
    end

    // Driven only from registered state, so no input reaches OUT combinationally.
    assign out_bit = busy & pat_q[idx];
endmodule

module pattern_seq_gen #(
    parameter int               DEPTH    = 16,
    parameter int               AW       = 4,
    parameter int               CH       = 2,
    parameter logic [DEPTH-1:0] INIT_PAT = 16'h1C3F,
    parameter int               CW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic [AW-1:0]    LEN,
    input  logic             LOAD,
    input  logic [CW-1:0]    LOAD_CH,
    input  logic [DEPTH-1:0] PAT_IN,
    output logic [CH-1:0]    OUT,
    output logic [AW-1:0]    IDX,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRAP
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] len_q, len_d;
    logic          mode_q, mode_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START && !STOP) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    len_d   = LEN;
                    mode_d  = MODE;
                end
            end
            S_RUN: begin
                // STOP wins over end-of-sequence: no DONE/WRAP on abort.
                if (STOP) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (idx_q == len_q) begin
                    idx_d = '0;
                    if (mode_q) begin
                        wrap_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign BUSY = (state_q == S_RUN);
    assign IDX  = idx_q;
    assign DONE = done_q;
    assign WRAP = wrap_q;

    logic [CH-1:0] we;

    // Out-of-range LOAD_CH matches no channel, so the write is dropped.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign we[c] = LOAD && (32'(LOAD_CH) == c);

        pattern_seq_chan #(
            .DEPTH   (DEPTH),
            .AW      (AW),
            .INIT_PAT(INIT_PAT)
        ) u_chan (
            .clk    (CLK),
            .rst_n  (RST_N),
            .we     (we[c]),
            .pat_in (PAT_IN),
            .busy   (BUSY),
            .idx    (idx_q),
            .out_bit(OUT[c])
        );
    end
endmodule
